delay_credit_rx: RTL and testbench

- Receive end of a fixed-latency multi-lane delay pipeline.
- Upstream launches a lane-vector into a DELAY-stage pipeline only when this block grants a credit. The vector arrives DELAY cycles later on ret_* and is captured into a FIFO.
- The FIFO presents data downstream with a valid/ready handshake, so a stalling consumer never loses pipeline data.
- Sits between a non-stallable datapath pipeline and a backpressured consumer stage.

---
 rtl/delay_credit_rx.sv | 97 +++++++++
 tb/tb_delay_credit_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_credit_rx.sv
// Receive end of a fixed-latency lane-vector pipeline: issues credits upstream and
// captures returning vectors into a show-ahead FIFO with a valid/ready output.
module delay_credit_rx #(
  parameter int unsigned BIT_WIDTH  = 4,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DELAY      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic                                 ret_valid,
  input  logic [BIT_WIDTH*DEPTH-1:0]           ret_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BIT_WIDTH*DEPTH-1:0]           out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      occupancy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      inflight,
  output logic                                 err
);

  localparam int unsigned DW = BIT_WIDTH * DEPTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Elaboration-time parameter sanity.
  if (FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("delay_credit_rx: FIFO_DEPTH must be a non-zero power of two");
  end
  if (FIFO_DEPTH < DELAY + 1) begin : g_low_depth
    $warning("delay_credit_rx: FIFO_DEPTH below DELAY+1 limits throughput");
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0] inflight_nx, occupancy_nx;
  logic [CW:0]   total_nx;
  logic [DW-1:0] out_data_nx;
  logic          iss_c, pop_c, has_credit_c, full_c, push_c, err_c, fwd_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (FIFO_DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  // Event decode, counter and pointer next-state.
  always_comb begin
    iss_c        = issue_valid & issue_ready;
    pop_c        = out_valid & out_ready;
    has_credit_c = (inflight != CW'(0)) | iss_c;
    full_c       = (occupancy == CW'(FIFO_DEPTH));
    push_c       = ret_valid & has_credit_c & (~full_c | pop_c);
    err_c        = (ret_valid & ~has_credit_c)
                 | (ret_valid & full_c & ~pop_c)
                 | (issue_valid & ~issue_ready);

    inflight_nx  = inflight + CW'(iss_c) - CW'(push_c);
    occupancy_nx = occupancy + CW'(push_c) - CW'(pop_c);
    total_nx     = (CW+1)'(inflight_nx) + (CW+1)'(occupancy_nx);

    wr_ptr_nx    = push_c ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nx    = pop_c  ? ptr_inc(rd_ptr) : rd_ptr;

    // A push landing in the slot that becomes head must be forwarded to the output register.
    fwd_c        = push_c & (wr_ptr == rd_ptr_nx);
    out_data_nx  = fwd_c ? ret_data : mem[rd_ptr_nx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= '0;
      occupancy   <= '0;
      issue_ready <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nx;
      rd_ptr      <= rd_ptr_nx;
      inflight    <= inflight_nx;
      occupancy   <= occupancy_nx;
      issue_ready <= (total_nx < (CW+1)'(FIFO_DEPTH));
      out_valid   <= (occupancy_nx != CW'(0));
      out_data    <= out_data_nx;
      err         <= err | err_c;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= ret_data;
  end

endmodule

// File: tb/tb_delay_credit_rx.sv
// Scoreboard bench for delay_credit_rx: models the upstream DELAY pipeline and the
// credit/FIFO accounting, queues captured vectors and compares them at the output.
module tb_delay_credit_rx;

  localparam int unsigned BW  = 4;
  localparam int unsigned DP  = 2;
  localparam int unsigned DLY = 4;
  localparam int unsigned FD  = 8;
  localparam int unsigned DW  = BW * DP;
  localparam int unsigned CW  = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          ret_valid = 1'b0;
  logic [DW-1:0] ret_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic          err;

  always #5 clk = ~clk;

  delay_credit_rx #(
    .BIT_WIDTH(BW), .DEPTH(DP), .DELAY(DLY), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .inflight(inflight), .err(err)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] q[$];
  bit            pipe_v[DLY];
  logic [DW-1:0] pipe_d[DLY];
  int            m_inf, m_occ, seq, base;
  bit            m_ready, m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear(input bit keep_pipe);
    m_inf = 0; m_occ = 0; m_ready = 1'b0; m_err = 1'b0;
    q.delete();
    if (!keep_pipe)
      for (int i = 0; i < int'(DLY); i++) pipe_v[i] = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ":issue_ready"}, 32'(issue_ready), 32'(m_ready));
    check({tag, ":occupancy"},   32'(occupancy),   32'(m_occ));
    check({tag, ":inflight"},    32'(inflight),    32'(m_inf));
    check({tag, ":out_valid"},   32'(out_valid),   32'(m_occ != 0));
    check({tag, ":err"},         32'(err),         32'(m_err));
    if (m_occ != 0 && q.size() != 0) check({tag, ":head"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock: drive at the falling edge, let the rising edge act, observe at the next falling edge.
  task automatic tick(input bit iv, input bit ordy, input bit xv, input logic [DW-1:0] xd);
    bit iss, pop, rv, push, credit;
    logic [DW-1:0] rd, exp;
    rv = pipe_v[DLY-1] | xv;
    rd = pipe_v[DLY-1] ? pipe_d[DLY-1] : xd;
    issue_valid = iv; out_ready = ordy; ret_valid = rv; ret_data = rd;

    iss    = iv & m_ready;
    pop    = (m_occ != 0) & ordy;
    credit = (m_inf > 0) || iss;
    push   = rv && credit && (m_occ < int'(FD) || pop);
    if ((rv && !credit) || (rv && m_occ == int'(FD) && !pop) || (iv && !m_ready)) m_err = 1'b1;

    if (pop) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop: scoreboard empty, got 0x%0h", out_data);
      end else begin
        exp = q.pop_front();
        check("pop", 32'(out_data), 32'(exp));
      end
    end
    if (push) q.push_back(rd);
    m_inf   = m_inf + int'(iss) - int'(push);
    m_occ   = m_occ + int'(push) - int'(pop);
    m_ready = (m_inf + m_occ) < int'(FD);

    for (int i = int'(DLY) - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = iss;
    pipe_d[0] = iss ? DW'(seq) : '0;
    if (iss) seq++;

    @(posedge clk);
    @(negedge clk);
    check_outs("tick");
  endtask

  task automatic do_reset(input bit mid_stream);
    rst_n = 1'b0;
    issue_valid = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
    #1;
    model_clear(mid_stream);
    check_outs("reset");
    check("reset:out_data", 32'(out_data), 32'(0));
    if (mid_stream) begin
      #1 rst_n = 1'b1;
    end else begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    check("reset:ready_low", 32'(issue_ready), 32'(0));
  endtask

  initial begin
    seq = 1;
    for (int i = 0; i < int'(DLY); i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
    #2;
    do_reset(1'b0);

    // Idle after reset: credit appears one clock later.
    tick(0, 0, 0, '0);
    check("idle:issue_ready", 32'(issue_ready), 32'(1));
    tick(0, 0, 0, '0);

    // Streaming 0x01..0x10 with an always-ready consumer.
    repeat (16) tick(1, 1, 0, '0);
    repeat (DLY + 3) tick(0, 1, 0, '0);
    check("stream:drained", 32'(occupancy), 32'(0));
    check("stream:err", 32'(err), 32'(0));

    // Backpressure: credit limit, single pop, then pointer wrap.
    do_reset(1'b0);
    tick(0, 0, 0, '0);
    repeat (12) tick(1, 0, 0, '0);
    repeat (DLY) tick(0, 0, 0, '0);
    check("bp:occ_full", 32'(occupancy), 32'(FD));
    check("bp:inflight0", 32'(inflight), 32'(0));
    check("bp:no_credit", 32'(issue_ready), 32'(0));
    tick(0, 1, 0, '0);
    check("bp:occ_after_pop", 32'(occupancy), 32'(FD - 1));
    check("bp:credit_back", 32'(issue_ready), 32'(1));
    repeat (24) tick(1, 1, 0, '0);
    repeat (DLY + 3) tick(0, 1, 0, '0);
    check("wrap:drained", 32'(occupancy), 32'(0));

    // Simultaneous push and pop at occupancy 3.
    do_reset(1'b0);
    tick(0, 0, 0, '0);
    base = seq;
    repeat (4) tick(1, 0, 0, '0);
    repeat (3) tick(0, 0, 0, '0);
    check("sim:occ3", 32'(occupancy), 32'(3));
    check("sim:head0", 32'(out_data), 32'(DW'(base)));
    tick(0, 1, 0, '0);
    check("sim:occ_hold", 32'(occupancy), 32'(3));
    check("sim:head1", 32'(out_data), 32'(DW'(base + 1)));

    // Launch while no credit is ignored and flagged.
    do_reset(1'b0);
    tick(1, 0, 0, '0);
    check("ign:inflight", 32'(inflight), 32'(0));
    check("ign:err", 32'(err), 32'(1));

    // Return with nothing in flight is dropped and flagged.
    do_reset(1'b0);
    tick(0, 0, 0, '0);
    tick(0, 0, 1, DW'(8'hAA));
    check("orphan:err", 32'(err), 32'(1));
    check("orphan:occ", 32'(occupancy), 32'(0));

    // Asynchronous reset with occupancy 5 and inflight 2; late returns are orphans.
    do_reset(1'b0);
    tick(0, 0, 0, '0);
    repeat (7) tick(1, 0, 0, '0);
    repeat (2) tick(0, 0, 0, '0);
    check("mid:occ5", 32'(occupancy), 32'(5));
    check("mid:inf2", 32'(inflight), 32'(2));
    do_reset(1'b1);
    repeat (3) tick(0, 0, 0, '0);
    check("mid:late_err", 32'(err), 32'(1));
    check("mid:late_occ", 32'(occupancy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
